add_stim: RTL and testbench

ADD_STIM -- requirements
Module: add_stim

---
 rtl/add_stim_pkg.sv | 21 ++
 rtl/lfsr16.sv | 36 +++
 rtl/add_stim.sv | 172 +++++++++++++++++
 tb/tb_add_stim.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/add_stim_pkg.sv
// Shared types and constants for the add_stim adder stimulus/checker.
// Holds the FSM state encoding, the LFSR tap mask and the operand seeds.
package add_stim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Feedback taps at bits 15, 13, 12 and 10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] SEED_A    = 16'hACE1;
  localparam logic [15:0] SEED_B    = 16'h1234;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {cur[14:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous load and single-step advance.
// load takes priority over step; reset clears the register.
module lfsr16
  import add_stim_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        step,
  output logic [15:0] q
);

  logic [15:0] q_q;
  logic [15:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = seed;
    end else if (step) begin
      q_d = lfsr_next(q_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/add_stim.sv
// Drives LFSR operand pairs into an external adder, samples its sum after a
// fixed settle time, and reports mismatch/vector counts for one run.
module add_stim
  import add_stim_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int NUM_VEC  = 16,
  parameter int WAIT_CYC = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       err_cnt,
  output logic [15:0]      vec_cnt,
  output state_e           state_o
);

  // start is a one-cycle request with no ready: it is accepted only when the
  // FSM sits in IDLE or DONE and silently dropped in any other state.

  localparam logic [15:0] WAIT_LAST = 16'(WAIT_CYC - 1);
  localparam logic [15:0] VEC_LAST  = 16'(NUM_VEC);

  state_e           state_q, state_d;
  logic [15:0]      wait_q, wait_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [7:0]       err_q, err_d;
  logic [15:0]      vec_q, vec_d;
  logic             pass_q, pass_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             lfsr_load;
  logic             lfsr_adv;
  logic [15:0]      lfsr_a_q;
  logic [15:0]      lfsr_b_q;
  logic [WIDTH-1:0] sum;
  logic [15:0]      vec_inc;
  logic             last_vec;
  logic             mismatch;

  lfsr16 u_lfsr_a (
    .clk  (clk),
    .rst  (rst),
    .load (lfsr_load),
    .seed (SEED_A),
    .step (lfsr_adv),
    .q    (lfsr_a_q)
  );

  lfsr16 u_lfsr_b (
    .clk  (clk),
    .rst  (rst),
    .load (lfsr_load),
    .seed (SEED_B),
    .step (lfsr_adv),
    .q    (lfsr_b_q)
  );

  assign sum      = a_q + b_q;
  assign vec_inc  = vec_q + 16'd1;
  assign last_vec = (vec_inc == VEC_LAST);

  // Default to mismatch so an unknown comparison result counts as an error.
  always_comb begin
    mismatch = 1'b1;
    if (C == sum) begin
      mismatch = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: if (start) state_d = ST_DRIVE;
      ST_DRIVE:         if (wait_q == WAIT_LAST) state_d = ST_CHECK;
      ST_CHECK:         state_d = last_vec ? ST_DONE : ST_DRIVE;
      default:          state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wait_d    = wait_q;
    a_d       = a_q;
    b_d       = b_q;
    err_d     = err_q;
    vec_d     = vec_q;
    pass_d    = pass_q;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          lfsr_load = 1'b1;
          a_d       = WIDTH'(SEED_A);
          b_d       = WIDTH'(SEED_B);
          err_d     = '0;
          vec_d     = '0;
          wait_d    = '0;
          pass_d    = 1'b0;
        end
      end
      ST_DRIVE: begin
        wait_d = (wait_q == WAIT_LAST) ? 16'd0 : wait_q + 16'd1;
      end
      ST_CHECK: begin
        lfsr_adv = 1'b1;
        vec_d    = vec_inc;
        if (mismatch && (err_q != 8'hFF)) begin
          err_d = err_q + 8'd1;
        end
        // The final vector's operands stay on A/B while the LFSRs move on.
        if (last_vec) begin
          pass_d = (err_d == 8'd0);
        end else begin
          a_d = WIDTH'(lfsr_next(lfsr_a_q));
          b_d = WIDTH'(lfsr_next(lfsr_b_q));
        end
      end
      default: ;
    endcase
    busy_d = (state_d == ST_DRIVE) || (state_d == ST_CHECK);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q <= '0;
      a_q    <= '0;
      b_q    <= '0;
      err_q  <= '0;
      vec_q  <= '0;
      pass_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      wait_q <= wait_d;
      a_q    <= a_d;
      b_q    <= b_d;
      err_q  <= err_d;
      vec_q  <= vec_d;
      pass_q <= pass_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign A       = a_q;
  assign B       = b_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign err_cnt = err_q;
  assign vec_cnt = vec_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_add_stim.sv
// Bench for add_stim: table of runs with per-vector sum corruption, randomized
// corruption rows, mid-run reset, busy-time start pulses and a saturation run.
module tb_add_stim;
  import add_stim_pkg::*;

  localparam int NV  = 16;
  localparam int NV2 = 300;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        start2 = 1'b0;
  logic [15:0] a_o, b_o, c_drv;
  logic        busy_o, done_o, pass_o;
  logic [7:0]  err_o;
  logic [15:0] vec_o;
  state_e      st_o;
  logic [15:0] a2_o, b2_o;
  logic        busy2_o, done2_o, pass2_o;
  logic [7:0]  err2_o;
  logic [15:0] vec2_o;
  state_e      st2_o;

  int total = 0;
  int bad   = 0;

  // Reference operand sequence and per-vector corruption applied to C.
  logic [15:0] seq_a [NV];
  logic [15:0] seq_b [NV];
  logic [15:0] mask  [NV];
  logic        zero_c = 1'b0;

  typedef struct {
    string name;
    bit    zero;
    int    flt_idx;
    bit    rnd;
    bit    noisy;
    int    exp_err;
    bit    exp_pass;
  } row_t;
  row_t tbl [7];

  always #5 clk = ~clk;

  add_stim #(.WIDTH(16), .NUM_VEC(NV), .WAIT_CYC(2)) dut (
    .clk(clk), .rst(rst), .start(start), .A(a_o), .B(b_o), .C(c_drv),
    .busy(busy_o), .done(done_o), .pass(pass_o), .err_cnt(err_o),
    .vec_cnt(vec_o), .state_o(st_o)
  );

  add_stim #(.WIDTH(16), .NUM_VEC(NV2), .WAIT_CYC(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .A(a2_o), .B(b2_o), .C(16'h0000),
    .busy(busy2_o), .done(done2_o), .pass(pass2_o), .err_cnt(err2_o),
    .vec_cnt(vec2_o), .state_o(st2_o)
  );

  // Adder under test: a correct sum, optionally corrupted on chosen vectors.
  always_comb begin
    c_drv = a_o + b_o;
    for (int i = 0; i < NV; i++) begin
      if (a_o == seq_a[i] && b_o == seq_b[i]) c_drv = (a_o + b_o) ^ mask[i];
    end
    if (zero_c) c_drv = 16'h0000;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic build_seq();
    logic [15:0] sa, sb;
    sa = 16'hACE1;
    sb = 16'h1234;
    for (int i = 0; i < NV; i++) begin
      seq_a[i] = sa;
      seq_b[i] = sb;
      sa = (sa << 1) | 16'(sa[15] ^ sa[13] ^ sa[12] ^ sa[10]);
      sb = (sb << 1) | 16'(sb[15] ^ sb[13] ^ sb[12] ^ sb[10]);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_row(input int r);
    int cnt;
    zero_c = tbl[r].zero;
    cnt = 0;
    for (int i = 0; i < NV; i++) begin
      mask[i] = '0;
      if (tbl[r].rnd && $urandom_range(0, 3) == 0) mask[i] = 16'($urandom_range(1, 16'hFFFF));
      if (i == tbl[r].flt_idx) mask[i] = 16'h0001;
      if (tbl[r].zero || mask[i] != 0) cnt++;
    end
    if (tbl[r].rnd) begin
      tbl[r].exp_err  = (cnt > 255) ? 255 : cnt;
      tbl[r].exp_pass = (cnt == 0);
    end
    pulse_start();
    chk({tbl[r].name, ".first_a"}, 32'(a_o), 32'hACE1);
    chk({tbl[r].name, ".first_b"}, 32'(b_o), 32'h1234);
    chk({tbl[r].name, ".first_sum"}, 32'(16'(a_o + b_o)), 32'hBF15);
    chk({tbl[r].name, ".busy"}, 32'(busy_o), 32'd1);
    chk({tbl[r].name, ".done_clr"}, 32'(done_o), 32'd0);
    for (int i = 0; i < NV; i++) begin
      chk($sformatf("%s.a%0d", tbl[r].name, i), 32'(a_o), 32'(seq_a[i]));
      chk($sformatf("%s.b%0d", tbl[r].name, i), 32'(b_o), 32'(seq_b[i]));
      for (int k = 0; k < 3; k++) begin
        start = tbl[r].noisy && (k == 0);
        @(negedge clk);
        start = 1'b0;
        if (i == NV - 1 && k == 1) chk({tbl[r].name, ".done_early"}, 32'(done_o), 32'd0);
      end
    end
    chk({tbl[r].name, ".done"}, 32'(done_o), 32'd1);
    chk({tbl[r].name, ".busy_end"}, 32'(busy_o), 32'd0);
    chk({tbl[r].name, ".err"}, 32'(err_o), 32'(tbl[r].exp_err));
    chk({tbl[r].name, ".pass"}, 32'(pass_o), 32'(tbl[r].exp_pass));
    chk({tbl[r].name, ".vec"}, 32'(vec_o), NV);
    @(negedge clk);
    chk({tbl[r].name, ".hold_a"}, 32'(a_o), 32'(seq_a[NV-1]));
    chk({tbl[r].name, ".hold_done"}, 32'(done_o), 32'd1);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".a"}, 32'(a_o), 32'd0);
    chk({tag, ".b"}, 32'(b_o), 32'd0);
    chk({tag, ".busy"}, 32'(busy_o), 32'd0);
    chk({tag, ".done"}, 32'(done_o), 32'd0);
    chk({tag, ".pass"}, 32'(pass_o), 32'd0);
    chk({tag, ".err"}, 32'(err_o), 32'd0);
    chk({tag, ".vec"}, 32'(vec_o), 32'd0);
    chk({tag, ".state"}, 32'(st_o), 32'(ST_IDLE));
  endtask

  initial begin
    int n;
    tbl[0] = '{"good",  1'b0, -1, 1'b0, 1'b0, 0,  1'b1};
    tbl[1] = '{"zero",  1'b1, -1, 1'b0, 1'b0, 16, 1'b0};
    tbl[2] = '{"flip3", 1'b0, 3,  1'b0, 1'b0, 1,  1'b0};
    tbl[3] = '{"rnd0",  1'b0, -1, 1'b1, 1'b0, 0,  1'b0};
    tbl[4] = '{"rnd1",  1'b0, -1, 1'b1, 1'b1, 0,  1'b0};
    tbl[5] = '{"rnd2",  1'b0, -1, 1'b1, 1'b0, 0,  1'b0};
    tbl[6] = '{"restart", 1'b0, -1, 1'b1, 1'b1, 0, 1'b0};
    build_seq();
    for (int i = 0; i < NV; i++) mask[i] = '0;

    // Reset for two cycles.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_state("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int r = 0; r < 6; r++) run_row(r);

    // Mid-run reset at vector 5, then a fresh run with busy-time start pulses.
    zero_c = 1'b0;
    for (int i = 0; i < NV; i++) mask[i] = '0;
    pulse_start();
    repeat (15) @(negedge clk);
    chk("mid.a5", 32'(a_o), 32'(seq_a[5]));
    chk("mid.vec5", 32'(vec_o), 32'd5);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_state("midrst");
    start = 1'b1;
    @(negedge clk);
    chk("rst_prio.busy", 32'(busy_o), 32'd0);
    chk("rst_prio.state", 32'(st_o), 32'(ST_IDLE));
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    run_row(6);

    // Long run with C tied low: error count saturates.
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    n = 0;
    while (!done2_o && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("sat.cycles", n, NV2 * 3);
    chk("sat.err", 32'(err2_o), 32'd255);
    chk("sat.vec", 32'(vec2_o), NV2);
    chk("sat.pass", 32'(pass2_o), 32'd0);
    chk("sat.busy", 32'(busy2_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
